prog_delay_line: RTL
====================

// Module: prog_delay_line
// PURPOSE
//  Parametrised, programmable-depth register delay line with per-stage valid tracking.
//  Aligns PRN-pattern and phase-detector sample words in the CDR datapath.
//  Successor to the single-bit D flip-flop:
//  - WIDTH-bit words and DEPTH stages.
//  - Clock enable and synchronous flush.
//  - Runtime tap select.
// PARAMETERS
//  WIDTH  8   data word width in bits (>=1)
//  DEPTH  16  number of register stages, i.e. maximum delay (>=2)
//  SEL_W  $clog2(DEPTH+1)  width of dly_sel; derived, do not override
// PORTS
//  clk         in   1      rising-edge clock, sole clock domain
//  rst         in   1      asynchronous, active-high reset
//  en          in   1      shift enable; chain advances only when 1
//  clr         in   1      synchronous flush; has priority over en
//  din         in   WIDTH  input word
//  din_valid   in   1      qualifies din; travels with the word
//  dly_sel     in   SEL_W  requested delay, in enabled cycles (legal 1..DEPTH)
//  dout        out  WIDTH  word at the selected tap
//  dout_valid  out  1      valid bit at the selected tap
//  sel_err     out  1      registered flag: last sampled dly_sel was out of range
// BEHAVIOUR
//  - One clock; reset is asynchronous and active-high.
//  - rst=1 (async):
//    - All stage words s[1..DEPTH] clear to 0; all valid bits v[1..DEPTH] clear to 0.
//    - sel_q clears to 1; sel_err clears to 0.
//    - Outputs therefore read dout=0 and dout_valid=0.
//  - Each edge, priority order:
//    - clr=1: all s[k] and v[k] load 0.
//    - else en=1: s[1]<=din, v[1]<=din_valid, s[k]<=s[k-1], v[k]<=v[k-1] for k=2..DEPTH.
//    - else: all stages hold.
//  - Tap select:
//    - sel_q<=clamp(dly_sel) every edge, independent of en and clr.
//    - Clamp rule: 0->1, >DEPTH->DEPTH.
//    - sel_err<=(dly_sel==0 || dly_sel>DEPTH), updated every edge.
//  - Output mux:
//    - dout=s[sel_q] and dout_valid=v[sel_q].
//    - Pure mux of registers; no combinational path from din, din_valid or dly_sel to outputs.
//  - Latency:
//    - A word accepted on an en=1 edge appears at dout after exactly sel_q en=1 edges, counting the accepting edge.
//    - en=0 cycles stretch the latency; they never drop or duplicate words.
//  - Tap change mid-stream:
//    - The new tap is visible one edge after dly_sel changes.
//    - dout_valid follows the valid bits of the new tap.
//    - Shrinking the delay skips words; growing the delay repeats words.
//    - No extra gating; the consumer is responsible for either case.
//  - clr with en=1 in the same cycle: flush wins and din is discarded.
//    - The first valid after the flush reaches tap N after N further en edges.
//  - Reset asserted mid-operation clears immediately (asynchronous). Release is assumed synchronised upstream.
// STRUCTURE
//  - Shared package cdr_pkg:
//    - constant function clog2.
//    - Default WIDTH/DEPTH constants.
//    - typedef/localparam for the SEL_W-wide select type, shared with the phase-alignment controller.
//  - One natural sub-module, dly_stage: a WIDTH+1-bit register (word plus valid) with async rst, sync clr and en.
//    - Instantiated DEPTH times by a generate loop.
//  - Top level holds sel_q, sel_err and the output mux.
// TESTING (WIDTH=8, DEPTH=16)
//  1. Reset: assert rst while clk is stopped.
//     -> dout=0x00, dout_valid=0, sel_err=0 at once. Release, no en -> all hold.
//  2. Fixed delay: dly_sel=5, en=1, din=0x01,0x02,... with din_valid=1.
//     -> 0x01 appears with dout_valid=1 exactly 5 edges after acceptance; one word per edge after that.
//  3. Enable gaps: dly_sel=3, en pattern 1,0,0,1,1,0,1.
//     -> output order unchanged, no loss or duplication; latency counts only en=1 edges.
//  4. Flush: fill chain (dly_sel=16), then pulse clr with en=1 and din=0xAA.
//     -> next edge dout_valid=0 and dout=0x00; 0xAA never appears; the next valid word needs 16 en edges.
//  5. Range errors: dly_sel=0 -> sel_err=1 and behaves as delay 1; dly_sel=20 -> sel_err=1 and behaves as delay 16.
//     Then dly_sel=7 -> sel_err=0 one edge later.
//  6. Live retune: streaming at dly_sel=8, switch to 4, later to 12.
//     -> tap changes one edge later; words are skipped or repeated as defined; dout_valid tracks v[sel_q].

Source files
------------

// File: rtl/cdr_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | cdr_pkg : shared constants, clog2 helper and tap-select type     |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package cdr_pkg;

  function automatic int clog2(input int value);
    int r;
    for (r = 0; (1 << r) < value; r++) begin
    end
    return r;
  endfunction

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 16;
  localparam int DEF_SEL_W = clog2(DEF_DEPTH + 1);

  // Tap-select word, also consumed by the phase-alignment controller
  typedef logic [DEF_SEL_W-1:0] sel_t;

endpackage
`default_nettype wire

// File: rtl/dly_stage.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dly_stage : one delay-line register (word plus valid bit)        |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module dly_stage #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  // Flush outranks shift so a same-cycle clr discards the incoming word
  always_comb begin
    q_d = q_q;
    if (clr)     q_d = '0;
    else if (en) q_d = d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q_q <= '0;
    else     q_q <= q_d;
  end

  assign q = q_q;

endmodule
`default_nettype wire

// File: rtl/prog_delay_line.sv
`default_nettype none
// +------------------------------------------------------------------+
// | prog_delay_line : programmable-depth delay line with valid bits  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module prog_delay_line
  import cdr_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int SEL_W = clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic [SEL_W-1:0] dly_sel,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             sel_err
);

  localparam logic [SEL_W-1:0] C_DEPTH_SEL = SEL_W'(DEPTH);
  localparam logic [SEL_W-1:0] C_ONE_SEL   = SEL_W'(1);

  logic [WIDTH:0] chain_in [1:DEPTH];
  logic [WIDTH:0] stage_q  [1:DEPTH];

  assign chain_in[1] = {din_valid, din};

  for (genvar k = 1; k <= DEPTH; k++) begin : g_stage
    if (k > 1) begin : g_link
      assign chain_in[k] = stage_q[k-1];
    end
    dly_stage #(.W(WIDTH + 1)) u_stage (
      .clk (clk),
      .rst (rst),
      .clr (clr),
      .en  (en),
      .d   (chain_in[k]),
      .q   (stage_q[k])
    );
  end

  logic [SEL_W-1:0] sel_q, sel_d;
  logic             sel_err_q, sel_err_d;

  always_comb begin
    sel_d     = dly_sel;
    sel_err_d = 1'b0;
    if (dly_sel == '0) begin
      sel_d     = C_ONE_SEL;
      sel_err_d = 1'b1;
    end else if (dly_sel > C_DEPTH_SEL) begin
      sel_d     = C_DEPTH_SEL;
      sel_err_d = 1'b1;
    end
  end

  // Tap select tracks dly_sel every edge, regardless of en/clr
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q     <= C_ONE_SEL;
      sel_err_q <= 1'b0;
    end else begin
      sel_q     <= sel_d;
      sel_err_q <= sel_err_d;
    end
  end

  logic [WIDTH:0] tap;

  always_comb begin
    tap = '0;
    for (int k = 1; k <= DEPTH; k++) begin
      if (sel_q == SEL_W'(k)) tap = stage_q[k];
    end
  end

  assign dout       = tap[WIDTH-1:0];
  assign dout_valid = tap[WIDTH];
  assign sel_err    = sel_err_q;

endmodule
`default_nettype wire
